// File: rtl/add_seq32.sv
// rtl/add_seq32.sv - multi-byte add/subtract sequencer over one shared 8-bit carry-lookahead adder
// One byte per cycle, LSB first; the carry between bytes lives in carry_q.

module cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s  = p ^ c[7:0];
    assign co = c[8];
endmodule

module add_seq32 #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         co
);
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  s_q, s_d;
    logic          carry_q, carry_d;
    logic          co_q, co_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [7:0]    cla_s;
    logic          cla_co;

    assign a_sh = a_q >> {idx_q, 3'b000};
    assign b_sh = b_q >> {idx_q, 3'b000};

    cla8 u_cla8 (
        .a  (a_sh[7:0]),
        .b  (b_sh[7:0]),
        .ci (carry_q),
        .s  (cla_s),
        .co (cla_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        co_d    = co_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    // Subtraction is a + ~b + 1, so B is stored inverted up front.
                    b_d     = sub ? ~b : b;
                    carry_d = sub | ci;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[{idx_q, 3'b000} +: 8] = cla_s;
                carry_d = cla_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    co_d    = cla_co;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            idx_q   <= idx_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;
endmodule

// File: tb/tb_add_seq32.sv
// tb/tb_add_seq32.sv - self-checking bench for add_seq32 against an arithmetic reference model
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_add_seq32;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;

    int n_cmp = 0;
    int n_bad = 0;

    add_seq32 #(.NBYTES(NB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .busy    (busy),
        .done    (done),
        .s       (s),
        .co      (co)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic civ, input logic subv);
        logic [W:0] r;
        if (subv) r = {(av >= bv), av - bv};
        else      r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, civ};
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic civ, input logic subv, input bit poke);
        logic [W:0] exp;
        int lat;
        int bcnt;
        int extra;
        exp = model(av, bv, civ, subv);
        @(negedge clk);
        a = av; b = bv; ci = civ; sub = subv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        bcnt = 0;
        while (!done && lat < 20) begin
            bcnt += int'(busy);
            if (poke && lat == 2) begin
                start = 1'b1; a = 32'hAAAAAAAA; b = 32'h55555555; sub = 1'b0;
            end
            if (lat == 3) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        bcnt += int'(busy);
        chk({tag, "_latency"}, 64'(lat), 64'(NB));
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(NB + 1));
        chk({tag, "_s"}, 64'(s), 64'(exp[W-1:0]));
        chk({tag, "_co"}, 64'(co), 64'(exp[W]));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'({done, busy}), 64'(0));
        chk({tag, "_s_held"}, 64'(s), 64'(exp[W-1:0]));
        if (poke) begin
            extra = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                extra += int'(done);
            end
            chk({tag, "_no_extra_done"}, 64'(extra), 64'(0));
        end
    endtask

    initial begin
        logic [W:0] q[$];
        logic [W:0] e;
        int ndone;

        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({busy, done, co, s}), 64'(0));
        reset_n = 1'b1;

        run_op("ripple",      32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run_op("full_chain",  32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0);
        run_op("sub_borrow",  32'h00000005, 32'h00000006, 1'b1, 1'b1, 1'b0);
        run_op("sub_noborrow",32'h12345678, 32'h02040608, 1'b0, 1'b1, 1'b0);
        run_op("sub_equal",   32'h89ABCDEF, 32'h89ABCDEF, 1'b0, 1'b1, 1'b0);
        run_op("busy_start",  32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_op("random", $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
        end

        // Abort mid-operation with an asynchronous reset.
        @(negedge clk);
        a = 32'h0F0F0F0F; b = 32'h01010101; ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_outputs", 64'({busy, done, co, s}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ndone += int'(done);
        end
        chk("abort_no_done", 64'(ndone), 64'(0));
        run_op("after_abort", 32'h00000010, 32'h00000020, 1'b0, 1'b0, 1'b0);

        // Start held high: acceptance every NB+2 edges, operands change every cycle.
        for (int i = 0; i <= 6 * 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_done_timing", 64'(done), 64'(((i - 1) % (NB + 2)) == NB));
                if (done) begin
                    if (q.size() == 0) begin
                        chk("b2b_queue_empty", 64'(1), 64'(0));
                    end else begin
                        e = q.pop_front();
                        chk("b2b_s", 64'(s), 64'(e[W-1:0]));
                        chk("b2b_co", 64'(co), 64'(e[W]));
                    end
                end
            end
            if (i < 6 * 4) begin
                a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
                start = 1'b1;
                if (i % (NB + 2) == 0) q.push_back(model(a, b, ci, sub));
            end else begin
                start = 1'b0;
            end
        end
        chk("b2b_all_done", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
